// File: rtl/mips_pkg.sv
// Shared opcode constants, hazard FSM state type and source-operand usage decode
// for the MIPS pipeline hazard controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    // lw reads rs as its base register; sw additionally reads rt as store data.
    function automatic logic uses_rs(input logic [5:0] op);
        logic used;
        case (op)
            OP_RTYPE, OP_BEQ, OP_LW, OP_SW: used = 1'b1;
            default:                        used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        logic used;
        case (op)
            OP_RTYPE, OP_BEQ, OP_SW: used = 1'b1;
            default:                 used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: ID/EX/MEM status in,
// PC / IF-ID / ID-EX steering out.
interface hazard_ctrl_if;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        mem_mem_read;
    logic [4:0]  mem_rd;
    logic        equal;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        branch_taken;
    logic        stalled;

    modport slave (
        input  id_inst, id_valid, ex_mem_read, ex_reg_write, ex_rd,
               mem_mem_read, mem_rd, equal,
        output pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, stalled
    );

    modport master (
        output id_inst, id_valid, ex_mem_read, ex_reg_write, ex_rd,
               mem_mem_read, mem_rd, equal,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, stalled
    );
endinterface

// File: rtl/hazard_dep_check.sv
// Combinational dependency detection for the instruction in ID and the number
// of stall cycles it needs before it may proceed (0, 1 or 2).
module hazard_dep_check
    import mips_pkg::*;
(
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output logic [1:0]  need_n,
    output logic        is_branch
);

    logic [5:0] op_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic       rs_used_s;
    logic       rt_used_s;
    logic       is_beq_s;
    logic       ex_dep_s;
    logic       ex_load_dep_s;
    logic       mem_dep_s;
    logic       unused_imm_s;

    assign op_s         = id_inst[31:26];
    assign rs_s         = id_inst[25:21];
    assign rt_s         = id_inst[20:16];
    assign unused_imm_s = ^id_inst[15:0];
    assign rs_used_s    = uses_rs(op_s);
    assign rt_used_s    = uses_rt(op_s);
    assign is_beq_s     = (op_s == OP_BEQ);
    assign is_branch    = id_valid & is_beq_s;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign ex_dep_s = id_valid & ex_reg_write & (ex_rd != 5'd0) &
                      ((rs_used_s & (rs_s == ex_rd)) | (rt_used_s & (rt_s == ex_rd)));
    assign ex_load_dep_s = ex_dep_s & ex_mem_read;
    assign mem_dep_s = id_valid & mem_mem_read & (mem_rd != 5'd0) &
                       ((rs_used_s & (rs_s == mem_rd)) | (rt_used_s & (rt_s == mem_rd)));

    // beq compares in ID, so it cannot use the EX/MEM forwarding paths ALU ops rely on.
    always_comb begin
        need_n = 2'd0;
        if (is_beq_s && ex_load_dep_s) begin
            need_n = 2'd2;
        end else if (is_beq_s && ex_dep_s) begin
            need_n = 2'd1;
        end else if (is_beq_s && mem_dep_s) begin
            need_n = 2'd1;
        end else if (!is_beq_s && ex_load_dep_s) begin
            need_n = 2'd1;
        end else begin
            need_n = 2'd0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch stall FSM and beq resolution.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  flush_count
`endif
);

    logic [1:0] need_n_s;
    logic       branch_s;
    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       stall_s;
    logic       pc_write_s;
    logic       ifid_write_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;
    logic       branch_taken_s;
    logic       stalled_s;

    hazard_dep_check u_dep (
        .id_inst      (hz.id_inst),
        .id_valid     (hz.id_valid),
        .ex_mem_read  (hz.ex_mem_read),
        .ex_reg_write (hz.ex_reg_write),
        .ex_rd        (hz.ex_rd),
        .mem_mem_read (hz.mem_mem_read),
        .mem_rd       (hz.mem_rd),
        .need_n       (need_n_s),
        .is_branch    (branch_s)
    );

    // Next state, remaining-stall counter and all pipeline control outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_s        = 1'b0;
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        branch_taken_s = 1'b0;
        stalled_s      = 1'b0;
        if (rst) begin
            state_d       = RUN;
            cnt_d         = 2'd0;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (need_n_s != 2'd0) begin
                        stall_s = 1'b1;
                        if (need_n_s == 2'd2) begin
                            state_d = STALL;
                            cnt_d   = 2'd1;
                        end else begin
                            state_d = RUN;
                            cnt_d   = 2'd0;
                        end
                    end else if (branch_s) begin
                        branch_taken_s = hz.equal;
                        ifid_flush_s   = hz.equal;
                    end else begin
                        cnt_d = 2'd0;
                    end
                end
                // Hazards are not re-evaluated here; the count fixed on entry is served out.
                STALL: begin
                    stall_s   = 1'b1;
                    stalled_s = 1'b1;
                    if (cnt_q > 2'd1) begin
                        state_d = STALL;
                        cnt_d   = cnt_q - 2'd1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                    stall_s = 1'b1;
                end
            endcase
            if (stall_s) begin
                pc_write_s    = 1'b0;
                ifid_write_s  = 1'b0;
                idex_bubble_s = 1'b1;
            end else begin
                pc_write_s    = 1'b1;
                ifid_write_s  = 1'b1;
                idex_bubble_s = 1'b0;
            end
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_write     = pc_write_s;
    assign hz.ifid_write   = ifid_write_s;
    assign hz.ifid_flush   = ifid_flush_s;
    assign hz.idex_bubble  = idex_bubble_s;
    assign hz.branch_taken = branch_taken_s;
    assign hz.stalled      = stalled_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Free-running statistics; wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall_s};
        flush_count_d  = flush_count_q + {31'd0, ifid_flush_s};
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// sequences and randomized stimulus against a rule-level reference model.
module tb_hazard_ctrl;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        ex_mr;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic        mem_mr;
        logic [4:0]  mem_rd;
        logic        equal;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [5:0] exp;
    } vec_t;

    // Output bundle order: pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, stalled
    localparam logic [5:0] NORMAL    = 6'b110000;
    localparam logic [5:0] STALL_RUN = 6'b000100;
    localparam logic [5:0] STALL_ST  = 6'b000101;
    localparam logic [5:0] TAKEN     = 6'b111010;
    localparam logic [5:0] RESET_O   = 6'b000100;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_stall;
    int   exp_flush;
    int   stall_left;
    vec_t tbl[$];

    hazard_ctrl_if hif();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h4020};
    endfunction

    function automatic stim_t mk(input logic [31:0] inst, input logic valid, input logic ex_mr,
                                 input logic ex_rw, input logic [4:0] ex_rd, input logic mem_mr,
                                 input logic [4:0] mem_rd, input logic equal);
        stim_t s;
        s.inst = inst; s.valid = valid; s.ex_mr = ex_mr; s.ex_rw = ex_rw;
        s.ex_rd = ex_rd; s.mem_mr = mem_mr; s.mem_rd = mem_rd; s.equal = equal;
        return s;
    endfunction

    task automatic add_vec(input stim_t s, input logic [5:0] e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    // Reference: stall count straight from the decode and priority rules.
    function automatic int model_n(input stim_t s);
        int op, rs, rt;
        bit beq, use_rs, use_rt, ex_hit, mem_hit;
        op = int'(s.inst[31:26]);
        rs = int'(s.inst[25:21]);
        rt = int'(s.inst[20:16]);
        beq    = (op == 4);
        use_rs = (op == 0) || (op == 4) || (op == 35) || (op == 43);
        use_rt = (op == 0) || (op == 4) || (op == 43);
        ex_hit  = s.valid && s.ex_rw && (s.ex_rd != 0) &&
                  ((use_rs && rs == int'(s.ex_rd)) || (use_rt && rt == int'(s.ex_rd)));
        mem_hit = s.valid && s.mem_mr && (s.mem_rd != 0) &&
                  ((use_rs && rs == int'(s.mem_rd)) || (use_rt && rt == int'(s.mem_rd)));
        if (beq && ex_hit && s.ex_mr) return 2;
        if (beq && ex_hit) return 1;
        if (beq && mem_hit) return 1;
        if (!beq && ex_hit && s.ex_mr) return 1;
        return 0;
    endfunction

    task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %b want %b (pc_wr,ifid_wr,flush,bubble,taken,stalled)",
                     name, $time, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        hif.id_inst      = s.inst;
        hif.id_valid     = s.valid;
        hif.ex_mem_read  = s.ex_mr;
        hif.ex_reg_write = s.ex_rw;
        hif.ex_rd        = s.ex_rd;
        hif.mem_mem_read = s.mem_mr;
        hif.mem_rd       = s.mem_rd;
        hif.equal        = s.equal;
    endtask

    // One clock: drive, sample mid-cycle, compare, keep the statistics model, advance.
    task automatic run_cycle(input stim_t s, input logic r, input logic [5:0] exp, input string name);
        logic [5:0] got;
        rst = r;
        drive(s);
        #4;
        got = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_bubble,
               hif.branch_taken, hif.stalled};
        check6(name, got, exp);
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (exp[5] == 1'b0) exp_stall++;
            if (exp[3] == 1'b1) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t idle, lu_stall, lu_next, beq_hit, beq_sw;
        checks = 0; failures = 0; exp_stall = 0; exp_flush = 0; stall_left = 0;
        idle = mk(ins(6'h00, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        drive(idle);

        run_cycle(idle, 1'b1, RESET_O, "reset_0");
        run_cycle(idle, 1'b1, RESET_O, "reset_1");
`ifdef HAZARD_STATS_EN
        check32("stats_reset_stall", stall_cycles, 32'd0);
        check32("stats_reset_flush", flush_count, 32'd0);
`endif

        // Single-cycle decisions, all starting and ending in RUN.
        add_vec(mk(ins(6'h00, 5'd8, 5'd1), 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h00, 5'd8, 5'd9), 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), STALL_RUN);
        add_vec(mk(ins(6'h00, 5'd8, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0), NORMAL);
        add_vec(mk(ins(6'h04, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), TAKEN);
        add_vec(mk(ins(6'h04, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h00, 5'd0, 5'd5), 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h2B, 5'd1, 5'd7), 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0), STALL_RUN);
        add_vec(mk(ins(6'h23, 5'd1, 5'd7), 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h04, 5'd3, 5'd2), 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1), STALL_RUN);
        add_vec(mk(ins(6'h04, 5'd1, 5'd4), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1), STALL_RUN);
        add_vec(mk(ins(6'h00, 5'd5, 5'd1), 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h00, 5'd6, 5'd1), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0), NORMAL);
        add_vec(mk(ins(6'h00, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h02, 5'd8, 5'd8), 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), NORMAL);
        add_vec(mk(ins(6'h04, 5'd0, 5'd0), 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1), TAKEN);
        add_vec(mk(ins(6'h04, 5'd9, 5'd1), 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1), NORMAL);
        foreach (tbl[i]) run_cycle(tbl[i].stim, 1'b0, tbl[i].exp, $sformatf("vec%0d", i));

        // beq on a load in EX: two stalled cycles, then it resolves.
        beq_hit = mk(ins(6'h04, 5'd1, 5'd9), 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1);
        run_cycle(beq_hit, 1'b0, STALL_RUN, "beq_lw_c1");
        beq_sw = mk(ins(6'h04, 5'd1, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
        run_cycle(beq_sw, 1'b0, STALL_ST, "beq_lw_c2");
        run_cycle(mk(ins(6'h04, 5'd1, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1),
                  1'b0, TAKEN, "beq_lw_c3");
        run_cycle(idle, 1'b0, NORMAL, "beq_lw_c4");

        // Reset while in STALL abandons the remaining stall.
        run_cycle(beq_hit, 1'b0, STALL_RUN, "rst_stall_c1");
        run_cycle(beq_sw, 1'b1, RESET_O, "rst_stall_rst");
`ifdef HAZARD_STATS_EN
        check32("stats_after_rst", stall_cycles, 32'd0);
`endif
        run_cycle(mk(ins(6'h00, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0),
                  1'b0, NORMAL, "rst_stall_resume");

        // Three load-use stalls and two taken branches.
        lu_stall = mk(ins(6'h00, 5'd8, 5'd3), 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        lu_next  = mk(ins(6'h00, 5'd8, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_cycle(lu_stall, 1'b0, STALL_RUN, $sformatf("lu%0d_stall", k));
            run_cycle(lu_next, 1'b0, NORMAL, $sformatf("lu%0d_next", k));
        end
        for (int k = 0; k < 2; k++) begin
            run_cycle(mk(ins(6'h04, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1),
                      1'b0, TAKEN, $sformatf("taken%0d", k));
        end
`ifdef HAZARD_STATS_EN
        check32("stats_stall_cycles", stall_cycles, 32'd3);
        check32("stats_flush_count", flush_count, 32'd2);
`endif

        // Random traffic against the rule-level model.
        stall_left = 0;
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            logic [5:0] op;
            logic [5:0] e;
            logic r;
            int n;
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h04;
                2: op = 6'h23;
                3: op = 6'h2B;
                default: op = 6'h02;
            endcase
            s = mk(ins(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                   ($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
            r = ($urandom_range(0, 99) < 3);
            if (r) begin
                e = RESET_O;
                stall_left = 0;
            end else if (stall_left > 0) begin
                e = STALL_ST;
                stall_left--;
            end else begin
                n = model_n(s);
                if (n > 0) begin
                    e = STALL_RUN;
                    stall_left = n - 1;
                end else if (s.valid && op == 6'h04) begin
                    e = s.equal ? TAKEN : NORMAL;
                end else begin
                    e = NORMAL;
                end
            end
            run_cycle(s, r, e, $sformatf("rand%0d", i));
        end
`ifdef HAZARD_STATS_EN
        check32("stats_rand_stall", stall_cycles, 32'(exp_stall));
        check32("stats_rand_flush", flush_count, 32'(exp_flush));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
